serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 175 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle unsigned subtractor: c = a - b (mod 2^WIDTH) with borrow-out,
//   processed CHUNK bits per clock, least significant chunk first. One
//   operation is in flight at a time.
//
//   Optional build macro: SERIAL_SUBTRACTOR_SATURATE_EN
//     defined   -> when the final borrow is 1, c is forced to 0 (saturating
//                  unsigned subtract); borrow still reports 1.
//     undefined -> c is the wrapped modulo result.
//   Latency and handshake are identical in both builds.
//
// Handshake (both sides): a transfer happens on a rising aclk edge where
//   valid and ready are both high. The input source holds a/b stable until it
//   sees in_ready; c/borrow are stable while out_valid is high and out_ready
//   is low. in_ready and out_valid are pure functions of the FSM state.
//
// Ports:
//   aclk       clock
//   arstn      asynchronous active-low reset
//   srst       synchronous active-high reset (same effect as arstn)
//   in_valid   operands a/b valid
//   in_ready   block idle and able to accept operands
//   a, b       minuend / subtrahend (WIDTH bits)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   c          difference (WIDTH bits), held until the next result
//   borrow     1 when a < b (unsigned)
//   dbg_state  FSM state for observation (IDLE=0, RUN=1, DONE=2)

module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             borrow,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               bin_q, bin_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // One chunk of the subtraction at CHUNK+1 bits; the top bit is the
  // borrow out of this chunk.
  logic [CHUNK:0]     chunk_diff;
  logic [WIDTH-1:0]   res_shift;

  assign chunk_diff = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                    - {{CHUNK{1'b0}}, bin_q};

  // The result register fills from the MSB side, so after NCHUNK shifts the
  // first (least significant) chunk has arrived at bit 0.
  generate
    if (NCHUNK == 1) begin : g_single
      assign res_shift = chunk_diff[CHUNK-1:0];
    end else begin : g_multi
      assign res_shift = {chunk_diff[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    c_d       = c_q;
    bin_d     = bin_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        res_d = res_shift;
        bin_d = chunk_diff[CHUNK];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          state_d  = S_DONE;
          borrow_d = chunk_diff[CHUNK];
          // c is a separate output register so it only changes when a new
          // result completes, never during a calculation.
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
          c_d = chunk_diff[CHUNK] ? '0 : res_shift;
`else
          c_d = res_shift;
`endif
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      c_q      <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (srst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      c_q      <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      c_q      <= c_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign c         = c_q;
  assign borrow    = borrow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=32/CHUNK=8 instance for the main
// checks and a WIDTH=32/CHUNK=32 instance for the single-chunk case. The
// reference model is plain unsigned arithmetic on whole operands.

`timescale 1ns/1ps

module tb_serial_subtractor;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic arstn;
  logic srst;
  always #5 aclk = ~aclk;

  // Main instance (NCHUNK = 4)
  logic         in_valid, in_ready, out_valid, out_ready, borrow;
  logic [W-1:0] a, b, c;
  logic [1:0]   dbg_state;

  // Single-chunk instance (NCHUNK = 1)
  logic         in1_valid, in1_ready, out1_valid, out1_ready, borrow1;
  logic [W-1:0] a1, b1, c1;
  logic [1:0]   dbg1_state;

  serial_subtractor #(.WIDTH(W), .CHUNK(8)) dut (
    .aclk(aclk), .arstn(arstn), .srst(srst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .borrow(borrow),
    .dbg_state(dbg_state)
  );

  serial_subtractor #(.WIDTH(W), .CHUNK(W)) dut1 (
    .aclk(aclk), .arstn(arstn), .srst(srst),
    .in_valid(in1_valid), .in_ready(in1_ready), .a(a1), .b(b1),
    .out_valid(out1_valid), .out_ready(out1_ready), .c(c1), .borrow(borrow1),
    .dbg_state(dbg1_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];   // {borrow, c}

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r[W]     = (x < y);
    r[W-1:0] = x - y;
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
    if (r[W]) r[W-1:0] = '0;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present operands and hold them until an accepting edge has passed.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    a = x;
    b = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model(x, y));
  endtask

  // Called right after the accepting edge; counts edges until out_valid.
  task automatic wait_result(input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("out_valid_hi", 64'(out_valid), 64'(1));
  endtask

  task automatic check_result(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      chk(tag, 64'({borrow, c}), 64'(e));
    end
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    out_ready = 1'b1;
    send(x, y);
    wait_result(4);
    check_result(tag);
    tick();
    chk("out_valid_drop", 64'(out_valid), 64'(0));
    chk("in_ready_back", 64'(in_ready), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] x, y, t;
    logic [W:0]   held, e1;

    arstn = 1'b0; srst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in1_valid = 1'b0; out1_ready = 1'b0; a1 = '0; b1 = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_c", 64'(c), 64'(0));
    chk("rst_borrow", 64'(borrow), 64'(0));
    tick(); tick();
    arstn = 1'b1;
    tick();

    // Directed patterns
    op(32'd100, 32'd58, "sub_100_58");
    op(32'd5, 32'd7, "sub_5_7");
    op(32'h0001_0000, 32'h0000_0001, "ripple");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "equal_max");
    op(32'h0000_0000, 32'hFFFF_FFFF, "zero_minus_max");

    // out_ready while idle has no effect
    out_ready = 1'b1;
    tick();
    chk("idle_out_ready", 64'(out_valid), 64'(0));

    // Randomised operations
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: y = x;
        2: if (x > y) begin t = x; x = y; y = t; end
        default: begin x = $urandom_range(0, 300); y = $urandom_range(0, 300); end
      endcase
      op(x, y, "random");
    end

    // Backpressure: result held, second request blocked until drained
    out_ready = 1'b0;
    x = $urandom_range(0, 1000);
    y = x + $urandom_range(1, 1000);
    send(x, y);
    wait_result(4);
    held = {borrow, c};
    check_result("bp_first");
    a = 32'h1234_5678;
    b = 32'h0000_9ABC;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_hold", 64'({borrow, c}), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    chk("bp_release_out_valid", 64'(out_valid), 64'(0));
    tick();
    chk("bp_second_accepted", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    exp_q.push_back(model(32'h1234_5678, 32'h0000_9ABC));
    wait_result(4);
    check_result("bp_second");
    tick();

    // srst on the 2nd RUN cycle aborts the operation
    op(32'd1234, 32'd5, "pre_srst");
    send(32'd77, 32'd33);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    void'(exp_q.pop_back());
    chk("srst_in_ready", 64'(in_ready), 64'(1));
    chk("srst_out_valid", 64'(out_valid), 64'(0));
    chk("srst_c", 64'(c), 64'(0));
    chk("srst_borrow", 64'(borrow), 64'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("srst_no_result", 64'(out_valid), 64'(0));
    end

    // arstn mid-cycle during RUN: outputs reset immediately
    op(32'd3, 32'd9999, "pre_arstn");
    send(32'd500, 32'd1);
    tick();
    #2;
    arstn = 1'b0;
    #1;
    void'(exp_q.pop_back());
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_c", 64'(c), 64'(0));
    chk("arst_borrow", 64'(borrow), 64'(0));
    tick();
    arstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_result", 64'(out_valid), 64'(0));
    end
    op(32'd40, 32'd2, "post_arstn");

    // Single-chunk instance: result one cycle after accept
    out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        x = 32'd3;
        y = 32'd1;
      end else begin
        x = $urandom;
        y = $urandom;
      end
      e1 = model(x, y);
      chk("n1_in_ready", 64'(in1_ready), 64'(1));
      a1 = x;
      b1 = y;
      in1_valid = 1'b1;
      tick();
      in1_valid = 1'b0;
      chk("n1_busy", 64'(out1_valid), 64'(0));
      tick();
      chk("n1_out_valid", 64'(out1_valid), 64'(1));
      chk("n1_result", 64'({borrow1, c1}), 64'(e1));
      tick();
      chk("n1_drop", 64'(out1_valid), 64'(0));
    end

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound
  initial begin
    #400000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
